// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle RISC-V control FSM with MD handshake, memory timeout and traps
module multicycle_control_unit #(
    parameter bit MD_ENABLE   = 1'b1,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    input  logic             branch_taken,
    input  logic             md_done,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       result_sel,
    output logic [3:0]       alu_ctrl,
    output logic [1:0]       alu_sel_rs1,
    output logic             alu_sel_rs2,
    output logic             md_start,
    output logic [2:0]       md_op,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired_count
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MD_WAIT, S_MEM, S_WB, S_TRAP
    } state_t;

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    state_t         state, next_state;
    logic [WCW-1:0] wait_cnt;
    logic           trap_q;
    logic [1:0]     cause_q, next_cause;
    logic           retire;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_r, is_i, is_lui, is_auipc, is_load, is_store;
    logic       is_branch, is_jal, is_jalr, is_m, is_md, legal;
    logic [3:0] alu_func;
    logic       unused_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign unused_bits = ^{instr[24:15], instr[11:7]};

    assign is_r      = (opcode == 7'b0110011);
    assign is_i      = (opcode == 7'b0010011);
    assign is_lui    = (opcode == 7'b0110111);
    assign is_auipc  = (opcode == 7'b0010111);
    assign is_load   = (opcode == 7'b0000011);
    assign is_store  = (opcode == 7'b0100011);
    assign is_branch = (opcode == 7'b1100011);
    assign is_jal    = (opcode == 7'b1101111);
    assign is_jalr   = (opcode == 7'b1100111);
    assign is_m      = is_r && (funct7 == 7'b0000001);
    assign is_md     = is_m && MD_ENABLE;
    assign legal     = (is_r && (!is_m || MD_ENABLE)) || is_i || is_lui || is_auipc
                     || is_load || is_store || is_branch || is_jal || is_jalr;

    // Subtract only exists in R-type; for I-type bit 30 is immediate except on shifts.
    always_comb begin
        case (funct3)
            3'b000:  alu_func = (is_r && instr[30]) ? 4'b0001 : 4'b0000;
            3'b001:  alu_func = 4'b0010;
            3'b010:  alu_func = 4'b0011;
            3'b011:  alu_func = 4'b0100;
            3'b100:  alu_func = 4'b0101;
            3'b101:  alu_func = instr[30] ? 4'b0111 : 4'b0110;
            3'b110:  alu_func = 4'b1000;
            default: alu_func = 4'b1001;
        endcase
    end

    always_comb begin
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        result_sel  = 2'd0;
        alu_ctrl    = 4'b0000;
        alu_sel_rs1 = 2'd0;
        alu_sel_rs2 = 1'b0;
        md_start    = 1'b0;
        md_op       = 3'd0;
        next_state  = state;
        next_cause  = cause_q;
        retire      = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = S_TRAP;
                    next_cause = 2'd2;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    next_state = S_EXEC;
                end else begin
                    next_state = S_TRAP;
                    next_cause = 2'd1;
                end
            end
            S_EXEC: begin
                alu_sel_rs2 = !is_r;
                if (is_md) begin
                    md_start   = 1'b1;
                    md_op      = funct3;
                    next_state = S_MD_WAIT;
                end else if (is_r || is_i || is_lui || is_auipc) begin
                    if (is_r || is_i)
                        alu_ctrl = alu_func;
                    alu_sel_rs1 = is_lui ? 2'd2 : (is_auipc ? 2'd1 : 2'd0);
                    next_state  = S_WB;
                end else if (is_load || is_store) begin
                    next_state = S_MEM;
                end else if (is_branch) begin
                    alu_sel_rs1 = 2'd1;
                    pc_src      = 1'b1;
                    pc_write    = branch_taken;
                    retire      = 1'b1;
                    next_state  = S_FETCH;
                end else begin
                    alu_sel_rs1 = is_jal ? 2'd1 : 2'd0;
                    pc_write    = 1'b1;
                    pc_src      = 1'b1;
                    reg_write   = 1'b1;
                    result_sel  = 2'd2;
                    retire      = 1'b1;
                    next_state  = S_FETCH;
                end
            end
            S_MD_WAIT: begin
                md_op = funct3;
                if (md_done)
                    next_state = S_WB;
            end
            S_MEM: begin
                mem_write = is_store;
                mem_read  = !is_store;
                if (mem_ready) begin
                    retire     = is_store;
                    next_state = is_store ? S_FETCH : S_WB;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = S_TRAP;
                    next_cause = 2'd3;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                result_sel = is_load ? 2'd1 : (is_md ? 2'd3 : 2'd0);
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_TRAP: begin
                next_state = S_TRAP;
            end
            default: next_state = S_FETCH;
        endcase
        if (rst) begin
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            pc_src      = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            reg_write   = 1'b0;
            result_sel  = 2'd0;
            alu_ctrl    = 4'b0000;
            alu_sel_rs1 = 2'd0;
            alu_sel_rs2 = 1'b0;
            md_start    = 1'b0;
            md_op       = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_FETCH;
            wait_cnt      <= '0;
            retired_count <= '0;
            trap_q        <= 1'b0;
            cause_q       <= 2'd0;
        end else begin
            state <= next_state;
            if (next_state != state)
                wait_cnt <= '0;
            else if ((state == S_FETCH || state == S_MEM) && !mem_ready)
                wait_cnt <= wait_cnt + WCW'(1);
            if (retire)
                retired_count <= retired_count + CNT_W'(1);
            if (next_state == S_TRAP && state != S_TRAP) begin
                trap_q  <= 1'b1;
                cause_q <= next_cause;
            end
        end
    end

    assign trap       = trap_q & ~rst;
    assign trap_cause = rst ? 2'd0 : cause_q;

endmodule
